iq_capture_ctrl: RTL and testbench

IQ_CAPTURE_CTRL -- requirements
Module: iq_capture_ctrl

---
 rtl/iq_capture_pkg.sv | 17 +
 rtl/iq_capture_wdog.sv | 34 +++
 rtl/iq_capture_ctrl.sv | 163 ++++++++++++++++
 tb/tb_iq_capture_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_capture_pkg.sv
// Shared types and default widths for the IQ capture controller and its watchdog.
package iq_capture_pkg;

    localparam int unsigned DEF_LEN_W    = 24;
    localparam int unsigned DEF_WDOG_W   = 16;
    localparam int unsigned STALL_INFO_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_FAULT
    } cap_state_e;

endpackage

// File: rtl/iq_capture_wdog.sv
// Stall watchdog: counts consecutive blocked cycles while enabled and flags the
// cycle on which the count reaches a nonzero limit.
module iq_capture_wdog #(
    parameter int unsigned WDOG_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              block,
    input  logic [WDOG_W-1:0] limit,
    output logic              expired
);

    logic [WDOG_W-1:0] blockCount_q, blockCount_d;

    always_comb begin
        blockCount_d = '0;
        if (enable && block) begin
            blockCount_d = (blockCount_q == '1) ? blockCount_q : blockCount_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blockCount_q <= '0;
        end else begin
            blockCount_q <= blockCount_d;
        end
    end

    // Fires on the limit-th consecutive blocked cycle, so the FSM leaves on that edge.
    assign expired = enable && block && (limit != '0) && (blockCount_q == limit - WDOG_W'(1));

endmodule

// File: rtl/iq_capture_ctrl.sv
// Capture controller sequencing the filter_iq HLS core and counting its output beats.
// Optional stall watchdog is built in when IQ_CAPTURE_CTRL_WDOG_EN is defined.
module iq_capture_ctrl
    import iq_capture_pkg::*;
#(
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter int unsigned WDOG_W = DEF_WDOG_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic [WDOG_W-1:0]       cfg_wdog_limit,
    output logic                    hls_ap_start,
    input  logic                    hls_ap_ready,
    input  logic                    hls_ap_done,
    input  logic                    beat_valid,
    input  logic                    beat_ready,
    input  logic                    mon_block,
    input  logic [STALL_INFO_W-1:0] mon_axis_info,
    output logic                    busy,
    output logic                    done,
    output logic                    stalled,
    output logic [STALL_INFO_W-1:0] stall_info,
    output logic [LEN_W-1:0]        beat_count
);

    cap_state_e              state_q, state_d;
    logic [LEN_W-1:0]        beatCount_q, beatCount_d;
    logic [LEN_W-1:0]        capLen_q, capLen_d;
    logic                    doneSeen_q, doneSeen_d;
    logic                    zeroDone_q, zeroDone_d;
    logic                    stalled_q, stalled_d;
    logic [STALL_INFO_W-1:0] stallInfo_q, stallInfo_d;
    logic                    startAccept;
    logic                    wdogEnable;
    logic                    wdogExpired;
    logic                    beatFire;
    logic [LEN_W-1:0]        beatNext;

    assign startAccept = (state_q == ST_IDLE) && cfg_start && !cfg_abort && (cfg_len != '0);
    assign wdogEnable  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign beatFire    = beat_valid && beat_ready;
    assign beatNext    = beatCount_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        beatCount_d = beatCount_q;
        capLen_d    = capLen_q;
        doneSeen_d  = doneSeen_q;
        zeroDone_d  = 1'b0;
        stalled_d   = stalled_q;
        stallInfo_d = stallInfo_q;
        case (state_q)
            ST_IDLE: begin
                if (startAccept) begin
                    state_d     = ST_START;
                    capLen_d    = cfg_len;
                    beatCount_d = '0;
                    doneSeen_d  = 1'b0;
                end else if (cfg_start && !cfg_abort) begin
                    zeroDone_d = 1'b1;
                end
            end
            ST_START: begin
                if (hls_ap_ready) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (hls_ap_done) doneSeen_d = 1'b1;
                if (wdogExpired) begin
                    state_d = ST_FAULT;
                end else if (beatFire) begin
                    if (beatCount_q != '1) beatCount_d = beatNext;
                    if (beatNext == capLen_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wdogExpired) begin
                    state_d = ST_FAULT;
                end else if (hls_ap_done || doneSeen_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_IDLE;
        endcase
        if (wdogExpired && state_d == ST_FAULT && state_q != ST_FAULT) begin
            stalled_d   = 1'b1;
            stallInfo_d = mon_axis_info;
        end
        // Abort overrides every other outcome of the cycle, including the beat count update.
        if (cfg_abort && state_q != ST_IDLE && state_q != ST_DONE) begin
            state_d     = ST_IDLE;
            beatCount_d = beatCount_q;
            stalled_d   = 1'b0;
            stallInfo_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            beatCount_q <= '0;
            capLen_q    <= '0;
            doneSeen_q  <= 1'b0;
            zeroDone_q  <= 1'b0;
            stalled_q   <= 1'b0;
            stallInfo_q <= '0;
        end else begin
            state_q     <= state_d;
            beatCount_q <= beatCount_d;
            capLen_q    <= capLen_d;
            doneSeen_q  <= doneSeen_d;
            zeroDone_q  <= zeroDone_d;
            stalled_q   <= stalled_d;
            stallInfo_q <= stallInfo_d;
        end
    end

`ifdef IQ_CAPTURE_CTRL_WDOG_EN
    logic [WDOG_W-1:0] wdogLimit_q, wdogLimit_d;

    assign wdogLimit_d = startAccept ? cfg_wdog_limit : wdogLimit_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            wdogLimit_q <= '0;
        end else begin
            wdogLimit_q <= wdogLimit_d;
        end
    end

    iq_capture_wdog #(
        .WDOG_W(WDOG_W)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .enable (wdogEnable),
        .block  (mon_block),
        .limit  (wdogLimit_q),
        .expired(wdogExpired)
    );

    assign stalled    = stalled_q;
    assign stall_info = stallInfo_q;
`else
    logic unusedWdogSignals;

    assign unusedWdogSignals = ^{mon_block, cfg_wdog_limit, wdogEnable, stalled_q, stallInfo_q};
    assign wdogExpired       = 1'b0;
    assign stalled           = 1'b0;
    assign stall_info        = '0;
`endif

    assign hls_ap_start = (state_q == ST_START);
    assign busy         = (state_q == ST_START) || (state_q == ST_RUN) ||
                          (state_q == ST_DRAIN) || (state_q == ST_DONE);
    assign done         = (state_q == ST_DONE) || zeroDone_q;
    assign beat_count   = beatCount_q;

endmodule

// File: tb/tb_iq_capture_ctrl.sv
// Directed self-checking bench for iq_capture_ctrl; watchdog scenarios follow
// whether IQ_CAPTURE_CTRL_WDOG_EN is defined.
module tb_iq_capture_ctrl;

    localparam int unsigned LEN_W  = 8;
    localparam int unsigned WDOG_W = 8;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cfg_abort = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic [WDOG_W-1:0] cfg_wdog_limit = '0;
    logic              hls_ap_start;
    logic              hls_ap_ready = 1'b0;
    logic              hls_ap_done = 1'b0;
    logic              beat_valid = 1'b0;
    logic              beat_ready = 1'b0;
    logic              mon_block = 1'b0;
    logic [3:0]        mon_axis_info = '0;
    logic              busy;
    logic              done;
    logic              stalled;
    logic [3:0]        stall_info;
    logic [LEN_W-1:0]  beat_count;

    int vectorCount = 0;
    int missCount   = 0;
    int donePulses  = 0;
    int apStartSeen = 0;

    iq_capture_ctrl #(
        .LEN_W (LEN_W),
        .WDOG_W(WDOG_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_abort     (cfg_abort),
        .cfg_len       (cfg_len),
        .cfg_wdog_limit(cfg_wdog_limit),
        .hls_ap_start  (hls_ap_start),
        .hls_ap_ready  (hls_ap_ready),
        .hls_ap_done   (hls_ap_done),
        .beat_valid    (beat_valid),
        .beat_ready    (beat_ready),
        .mon_block     (mon_block),
        .mon_axis_info (mon_axis_info),
        .busy          (busy),
        .done          (done),
        .stalled       (stalled),
        .stall_info    (stall_info),
        .beat_count    (beat_count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done === 1'b1) donePulses++;
        if (hls_ap_start === 1'b1) apStartSeen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of control inputs, then land 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic start, input logic abort, input logic valid,
                                 input logic ready, input logic apReady, input logic apDone,
                                 input logic block);
        cfg_start    = start;
        cfg_abort    = abort;
        beat_valid   = valid;
        beat_ready   = ready;
        hls_ap_ready = apReady;
        hls_ap_done  = apDone;
        mon_block    = block;
        @(posedge clock);
        #1;
    endtask

    task automatic startCapture(input logic [LEN_W-1:0] len, input logic [WDOG_W-1:0] limit);
        cfg_len        = len;
        cfg_wdog_limit = limit;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        int pulsesBefore;
        int apBefore;
        logic sawStall;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_apstart", hls_ap_start, 0);
        checkOutput("rst_count", beat_count, 0);
        checkOutput("rst_stalled", stalled, 0);
        checkOutput("rst_info", stall_info, 0);

        // Length 8, ap_ready after two cycles, one backpressured beat, late cfg change
        pulsesBefore = donePulses;
        cfg_len = 8;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("s8_apstart", hls_ap_start, 1);
        checkOutput("s8_busy", busy, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("s8_apstart_hold", hls_ap_start, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("s8_run_apstart", hls_ap_start, 0);
        cfg_len = 2;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("s8_backpressure", beat_count, 4);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("s8_count", beat_count, 8);
        checkOutput("s8_drain_busy", busy, 1);
        checkOutput("s8_drain_nodone", done, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("s8_done", done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("s8_done_end", done, 0);
        checkOutput("s8_idle_busy", busy, 0);
        checkOutput("s8_hold_count", beat_count, 8);
        checkOutput("s8_pulses", donePulses - pulsesBefore, 1);

        // ap_done arriving during RUN completes DRAIN in one cycle
        startCapture(2, 0);
        applyStimulus(0, 0, 1, 1, 0, 1, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("early_drain_busy", busy, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("early_done", done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Zero length request
        apBefore = apStartSeen;
        pulsesBefore = donePulses;
        cfg_len = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("zero_done", done, 1);
        checkOutput("zero_busy", busy, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("zero_pulses", donePulses - pulsesBefore, 1);
        checkOutput("zero_apstart", apStartSeen - apBefore, 0);

        // Start and abort together in IDLE
        cfg_len = 4;
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        checkOutput("idle_abort_busy", busy, 0);
        checkOutput("idle_abort_apstart", hls_ap_start, 0);

        // Abort in the same cycle as the final beat
        pulsesBefore = donePulses;
        startCapture(3, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 1, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count", beat_count, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("abort_nodone", donePulses - pulsesBefore, 0);

        // Abort while waiting for ap_ready
        cfg_len = 5;
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("abort_start_apstart", hls_ap_start, 0);
        checkOutput("abort_start_busy", busy, 0);

        // Reset mid-capture after three beats, then a normal capture
        startCapture(8, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0);
        checkOutput("pre_rst_count", beat_count, 3);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_count", beat_count, 0);
        checkOutput("mid_rst_apstart", hls_ap_start, 0);
        checkOutput("mid_rst_done", done, 0);
        pulsesBefore = donePulses;
        startCapture(2, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("post_rst_done", done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("post_rst_count", beat_count, 2);
        checkOutput("post_rst_pulses", donePulses - pulsesBefore, 1);

`ifdef IQ_CAPTURE_CTRL_WDOG_EN
        // Five blocked cycles against limit 5 trip the watchdog
        mon_axis_info = 4'hC;
        startCapture(8, 5);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("wd4_stalled", stalled, 0);
        checkOutput("wd4_busy", busy, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("wd_stalled", stalled, 1);
        checkOutput("wd_info", stall_info, 4'hC);
        checkOutput("wd_fault_busy", busy, 0);
        mon_axis_info = 4'h3;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("wd_sticky", stalled, 1);
        checkOutput("wd_info_hold", stall_info, 4'hC);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("wd_abort_stalled", stalled, 0);
        checkOutput("wd_abort_info", stall_info, 0);
        checkOutput("wd_abort_busy", busy, 0);

        // Four blocked cycles then release: no fault, capture completes
        pulsesBefore = donePulses;
        startCapture(2, 5);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("wd_nofault_stalled", stalled, 0);
        checkOutput("wd_nofault_done", done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("wd_nofault_pulses", donePulses - pulsesBefore, 1);
`else
        // Without the watchdog a long block never faults
        sawStall = 1'b0;
        pulsesBefore = donePulses;
        mon_axis_info = 4'hC;
        startCapture(2, 5);
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            if (stalled !== 1'b0 || stall_info !== 4'h0) sawStall = 1'b1;
        end
        checkOutput("nowd_stalled", sawStall, 0);
        checkOutput("nowd_busy", busy, 1);
        applyStimulus(0, 0, 1, 1, 0, 0, 1);
        applyStimulus(0, 0, 1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("nowd_done", done, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("nowd_count", beat_count, 2);
        checkOutput("nowd_pulses", donePulses - pulsesBefore, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
